accum_wb: RTL and testbench
===========================

Name: accum_wb

Overview:
- Per-row read-modify-write accumulator that sits directly upstream of the output-memory array.
- Takes partial sums from the systolic-array columns and reads the current accumulator word from the output memory's read port.
- Adds the two and writes the result back through the output memory's write port.
- ACCUM_ROW identical lanes; same-address back-to-back updates are resolved by forwarding, so no stalls are ever needed.

Parameters:
ACCUM_ROW, 256, number of independent lanes (one per output-memory bank)
DATA_WIDTH, 32, accumulator / memory word width (signed two's complement)
PSUM_WIDTH, 32, incoming partial-sum width; must be <= DATA_WIDTH; sign-extended
ADDR_WIDTH, 8, memory address width (bank depth 2^ADDR_WIDTH)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
psum_valid  in  ACCUM_ROW  per-lane partial-sum strobe
psum_first  in  ACCUM_ROW  1 = overwrite (first contribution), 0 = accumulate
psum_addr  in  ADDR_WIDTH x ACCUM_ROW  target word per lane
psum_data  in  PSUM_WIDTH x ACCUM_ROW  signed partial sum per lane
mem_rd_en  out  ACCUM_ROW  to memory read port enable
mem_rd_addr  out  ADDR_WIDTH x ACCUM_ROW  to memory read address
mem_rd_data  in  DATA_WIDTH x ACCUM_ROW  memory read data, valid 1 cycle after mem_rd_en
mem_wr_en  out  ACCUM_ROW  to memory write enable
mem_wr_addr  out  ADDR_WIDTH x ACCUM_ROW  write address
mem_wr_data  out  DATA_WIDTH x ACCUM_ROW  write data
idle  out  1  1 when no lane has an update in flight

Behaviour:
- Reset: on rst high at a clock edge, the following clear to 0: all stage registers, forward registers, mem_wr_en, mem_wr_addr, mem_wr_data. idle = 1.
- Input rules: no handshake and no backpressure; psum_valid is accepted every cycle.
- psum inputs arriving while rst is high are dropped; their reads may issue but nothing is written.
- Stage A (cycle t):
  - mem_rd_en = psum_valid and mem_rd_addr = psum_addr, combinational pass-through.
  - mem_rd_en is forced to 0 when psum_first = 1.
  - valid, first, addr and sign-extended psum are registered into s1.
- Stage B (cycle t+1): operand selection, in priority order:
  1. first = 1: operand = 0.
  2. wr_q valid and wr_q.addr == s1.addr: operand = wr_q.data (write issuing this cycle).
  3. wr_qq valid and wr_qq.addr == s1.addr: operand = wr_qq.data (write issued last cycle, still invisible to the read port).
  4. Otherwise: operand = mem_rd_data.
  - sum = operand + s1.psum, DATA_WIDTH wide, registered into wr_q.
- Write (cycle t+2): mem_wr_en/addr/data driven from wr_q, fully registered.
  - wr_q shifts into wr_qq every cycle; wr_qq.valid clears when no write occurs.
- Latency: input to write issue = 2 cycles; throughput 1 update/lane/cycle.
- Required result: any same-address sequence, including every cycle consecutively, produces exactly the sequential sum.
- Memory read-during-write on opposite ports is treated as returning old data; forwarding covers it.
- Lanes are fully independent; no cross-lane interaction.
- idle = NOT(OR over lanes of s1.valid | wr_q.valid).
- Default arithmetic wraps modulo 2^DATA_WIDTH.

Optional Feature:
- Macro: ACCUM_WB_SAT_EN.
- Defined:
  - Signed saturating add: clamp to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
  - Adds output sat_flag (ACCUM_ROW): a per-lane sticky bit, set on any clamp, cleared only by rst.
- Undefined: wrap-around add; no sat_flag port.

Decomposition:
- Package accum_pkg holds:
  - ACCUM_ROW, DATA_WIDTH, PSUM_WIDTH, ADDR_WIDTH defaults.
  - Typedef acc_word_t.
  - Typedef acc_addr_t.
  - Packed struct wb_entry_t {valid, addr, data} used by s1, wr_q and wr_qq.
- One sub-module, accum_wb_lane: single-lane pipeline plus forwarding.
- Top level generates ACCUM_ROW lanes and ORs the lane busy bits into idle.

Test Plan:
- Single update, lane 0, addr 5, first = 1, psum 7 -> mem_wr_en at t+2, addr 5, data 7; no read issued; idle back to 1 at t+3.
- Memory word 10 at addr 3; psum 4 with first = 0 -> read at t, write 14 at t+2.
- Addr 9, five consecutive cycles, first = 1 then 0, psums 1,2,3,4,5 -> writes 1,3,6,10,15.
- Gap pattern on addr 2 (first = 1 psum 100, idle, psum 1, idle, psum 1) -> writes 100, 101, 102; this exercises the wr_qq path.
- 4 lanes, mixed addresses and valids each cycle, random 200 cycles -> memory contents match a scoreboard model.
- Wrap/saturation:
  - Word 0x7FFFFFFF + psum 1 -> 0x80000000 without ACCUM_WB_SAT_EN.
  - Same stimulus with ACCUM_WB_SAT_EN -> 0x7FFFFFFF and sat_flag[lane] = 1.
- Reset mid-stream: rst asserted with writes in flight -> mem_wr_en = 0 the next cycle and idle = 1.

Source files
------------

// File: rtl/accum_pkg.sv
// accum_pkg: shared widths, types and helpers for the accum_wb read-modify-write
// accumulator.
//
// The word, address and partial-sum widths are fixed here. ACCUM_ROW is only the default
// lane count, and the top level can override it.
//
// Optional feature macro: ACCUM_WB_SAT_EN (see accum_wb.sv).
package accum_pkg;

  localparam int unsigned ACCUM_ROW  = 256;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned PSUM_WIDTH = 32;  // must be <= DATA_WIDTH
  localparam int unsigned ADDR_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] acc_word_t;
  typedef logic [ADDR_WIDTH-1:0] acc_addr_t;
  typedef logic [PSUM_WIDTH-1:0] acc_psum_t;

  // One pipeline slot. s1, the write register and the delayed write register all use it.
  typedef struct packed {
    logic      valid;
    acc_addr_t addr;
    acc_word_t data;
  } wb_entry_t;

  // Signed limits for the saturating build.
  localparam acc_word_t ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam acc_word_t ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Sign-extend a partial sum to accumulator width.
  function automatic acc_word_t sext_psum(acc_psum_t p);
    logic signed [PSUM_WIDTH-1:0] p_s;
    logic signed [DATA_WIDTH-1:0] w_s;
    p_s = p;
    w_s = p_s;
    return acc_word_t'(w_s);
  endfunction

endpackage

// File: rtl/accum_wb_lane.sv
// accum_wb_lane: single-lane read-modify-write accumulator with write forwarding.
//
// Pipeline stages:
//   Stage A (t)   : the read request passes straight through to memory, and the update is
//                   captured into s1.
//   Stage B (t+1) : select the operand (zero, forward from the write register, forward from
//                   the delayed write register, or memory data), add, and capture into wr_q.
//   Write   (t+2) : the memory write is driven directly from wr_q.
//
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   psum_valid_i / first_i       update strobe; first = overwrite instead of accumulate
//   psum_addr_i, psum_data_i     target word and signed partial sum
//   mem_rd_en_o, mem_rd_addr_o   memory read request (combinational from the inputs)
//   mem_rd_data_i                memory read data, one cycle after the request
//   mem_wr_en_o/addr_o/data_o    registered memory write
//   sat_flag_o                   sticky clamp flag (only when ACCUM_WB_SAT_EN is defined)
//   busy_o                       an update is in s1 or wr_q
module accum_wb_lane
  import accum_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psum_valid_i,
  input  logic                  psum_first_i,
  input  logic [ADDR_WIDTH-1:0] psum_addr_i,
  input  logic [PSUM_WIDTH-1:0] psum_data_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
`ifdef ACCUM_WB_SAT_EN
  output logic                  sat_flag_o,
`endif
  output logic                  busy_o
);

  wb_entry_t s1_q, s1_d;
  logic      s1_first_q, s1_first_d;
  wb_entry_t wr_q, wr_d;
  wb_entry_t wr_qq_q, wr_qq_d;

  acc_word_t operand;
  acc_word_t sum_wrap;
  acc_word_t sum;

  // Stage A. A first contribution never needs the old word, so it issues no read.
  assign mem_rd_en_o   = psum_valid_i & ~psum_first_i;
  assign mem_rd_addr_o = psum_addr_i;

  always_comb begin
    s1_d       = '0;
    s1_first_d = 1'b0;
    if (psum_valid_i) begin
      s1_d.valid = 1'b1;
      s1_d.addr  = psum_addr_i;
      s1_d.data  = sext_psum(psum_data_i);
      s1_first_d = psum_first_i;
    end
  end

  // Stage B. wr_q is being written this cycle. wr_qq_q was written last cycle, but the read
  // issued alongside that write still returned the old word. Both hazards are forwarded,
  // and the newer write takes priority.
  always_comb begin
    operand = mem_rd_data_i;
    if (s1_first_q) begin
      operand = '0;
    end else if (wr_q.valid && (wr_q.addr == s1_q.addr)) begin
      operand = wr_q.data;
    end else if (wr_qq_q.valid && (wr_qq_q.addr == s1_q.addr)) begin
      operand = wr_qq_q.data;
    end
    sum_wrap = operand + s1_q.data;
  end

`ifdef ACCUM_WB_SAT_EN
  logic ovf;
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    // Overflow occurs only when both addends share a sign that the wrapped result lacks.
    ovf = (operand[DATA_WIDTH-1] == s1_q.data[DATA_WIDTH-1]) &&
          (sum_wrap[DATA_WIDTH-1] != operand[DATA_WIDTH-1]);
    sum = sum_wrap;
    if (ovf) begin
      sum = operand[DATA_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
    sat_flag_d = sat_flag_q | (s1_q.valid & ovf);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag_o = sat_flag_q;
`else
  assign sum = sum_wrap;
`endif

  always_comb begin
    wr_d = '0;
    if (s1_q.valid) begin
      wr_d.valid = 1'b1;
      wr_d.addr  = s1_q.addr;
      wr_d.data  = sum;
    end
    wr_qq_d = wr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= '0;
      s1_first_q <= 1'b0;
      wr_q       <= '0;
      wr_qq_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_first_q <= s1_first_d;
      wr_q       <= wr_d;
      wr_qq_q    <= wr_qq_d;
    end
  end

  assign mem_wr_en_o   = wr_q.valid;
  assign mem_wr_addr_o = wr_q.addr;
  assign mem_wr_data_o = wr_q.data;
  assign busy_o        = s1_q.valid | wr_q.valid;

endmodule

// File: rtl/accum_wb.sv
// accum_wb: per-row read-modify-write accumulator in front of the output memory.
//
// This module instantiates ACCUM_ROW independent lanes (accum_wb_lane), one per memory
// bank. A lane adds each incoming partial sum to the word currently in memory and writes
// the result back two cycles later. Back-to-back updates to the same address are
// forwarded, so the block never stalls.
//
// Vector ports are packed flat, with lane i at slice [i*W +: W].
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   psum_valid, psum_first    per-lane update strobe and overwrite flag
//   psum_addr, psum_data      per-lane target address and signed partial sum
//   mem_rd_en, mem_rd_addr    to the memory read port (combinational)
//   mem_rd_data               from the memory read port, one cycle after mem_rd_en
//   mem_wr_en/addr/data       to the memory write port (registered)
//   sat_flag                  per-lane sticky saturation flag (ACCUM_WB_SAT_EN only)
//   idle                      no lane has an update in flight
//
// Build option: define ACCUM_WB_SAT_EN to get signed saturating adds plus the sat_flag
// port. Without it, sums wrap modulo 2^DATA_WIDTH.
module accum_wb
  import accum_pkg::*;
#(
  parameter int unsigned ACCUM_ROW = accum_pkg::ACCUM_ROW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ACCUM_ROW-1:0]            psum_valid,
  input  logic [ACCUM_ROW-1:0]            psum_first,
  input  logic [ACCUM_ROW*ADDR_WIDTH-1:0] psum_addr,
  input  logic [ACCUM_ROW*PSUM_WIDTH-1:0] psum_data,
  output logic [ACCUM_ROW-1:0]            mem_rd_en,
  output logic [ACCUM_ROW*ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [ACCUM_ROW*DATA_WIDTH-1:0] mem_rd_data,
  output logic [ACCUM_ROW-1:0]            mem_wr_en,
  output logic [ACCUM_ROW*ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ACCUM_ROW*DATA_WIDTH-1:0] mem_wr_data,
`ifdef ACCUM_WB_SAT_EN
  output logic [ACCUM_ROW-1:0]            sat_flag,
`endif
  output logic                            idle
);

  logic [ACCUM_ROW-1:0] busy;

  for (genvar g = 0; g < ACCUM_ROW; g++) begin : g_lane
    accum_wb_lane u_lane (
      .clk_i         (clk),
      .rst_i         (rst),
      .psum_valid_i  (psum_valid[g]),
      .psum_first_i  (psum_first[g]),
      .psum_addr_i   (psum_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .psum_data_i   (psum_data[g*PSUM_WIDTH +: PSUM_WIDTH]),
      .mem_rd_en_o   (mem_rd_en[g]),
      .mem_rd_addr_o (mem_rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_rd_data_i (mem_rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .mem_wr_en_o   (mem_wr_en[g]),
      .mem_wr_addr_o (mem_wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_wr_data_o (mem_wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
`ifdef ACCUM_WB_SAT_EN
      .sat_flag_o    (sat_flag[g]),
`endif
      .busy_o        (busy[g])
    );
  end

  assign idle = ~|busy;

endmodule

// File: tb/tb_accum_wb.sv
// tb_accum_wb: directed table plus hand-written sequences for accum_wb with 4 lanes.
// A behavioural two-port memory sits on the DUT memory ports. Its read data is registered,
// and a read that coincides with a write returns the old word.
module tb_accum_wb;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NL-1:0]    psum_valid, psum_first;
  logic [NL*AW-1:0] psum_addr;
  logic [NL*DW-1:0] psum_data;
  logic [NL-1:0]    mem_rd_en;
  logic [NL*AW-1:0] mem_rd_addr;
  logic [NL*DW-1:0] mem_rd_data;
  logic [NL-1:0]    mem_wr_en;
  logic [NL*AW-1:0] mem_wr_addr;
  logic [NL*DW-1:0] mem_wr_data;
`ifdef ACCUM_WB_SAT_EN
  logic [NL-1:0]    sat_flag;
`endif
  logic             idle;

  accum_wb #(.ACCUM_ROW(NL)) dut (
    .clk         (clk),
    .rst         (rst),
    .psum_valid  (psum_valid),
    .psum_first  (psum_first),
    .psum_addr   (psum_addr),
    .psum_data   (psum_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
`ifdef ACCUM_WB_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .idle        (idle)
  );

  // Memory model. All writes go through this block; ld_* preloads words.
  logic [DW-1:0] mem [NL][256];
  logic          ld_en = 1'b0;
  int            ld_lane = 0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_val = '0;

  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (mem_rd_en[l]) mem_rd_data[l*DW +: DW] <= mem[l][mem_rd_addr[l*AW +: AW]];
      if (mem_wr_en[l]) mem[l][mem_wr_addr[l*AW +: AW]] <= mem_wr_data[l*DW +: DW];
    end
    if (ld_en) mem[ld_lane][ld_addr] <= ld_val;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    psum_valid = '0;
    psum_first = '0;
    psum_addr  = '0;
    psum_data  = '0;
  endtask

  task automatic load(input int l, input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_lane = l;
    ld_addr = a;
    ld_val  = v;
  endtask

  typedef struct {
    logic          v;
    logic          f;
    logic [AW-1:0] a;
    logic [DW-1:0] p;
    logic          erd;
    logic          ewr;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
    logic          eidle;
  } vec_t;

  function automatic vec_t mk(logic v, logic f, logic [AW-1:0] a, logic [DW-1:0] p,
                              logic erd, logic ewr, logic [AW-1:0] ewa, logic [DW-1:0] ewd,
                              logic eidle);
    vec_t r;
    r.v = v; r.f = f; r.a = a; r.p = p;
    r.erd = erd; r.ewr = ewr; r.ewa = ewa; r.ewd = ewd; r.eidle = eidle;
    return r;
  endfunction

  vec_t          tbl[$];
  logic [DW-1:0] wrap_exp;
  logic [DW-1:0] gold [NL][4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish after 1000000 ns, required finish");
    $fatal(1);
  end

  initial begin
`ifdef ACCUM_WB_SAT_EN
    wrap_exp = 32'h7FFF_FFFF;
`else
    wrap_exp = 32'h8000_0000;
`endif
    // Per-cycle rows for lane 0. Each row gives the inputs driven in that cycle and the
    // outputs expected in that same cycle.
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    // Single first=1 update: no read, write at t+2, idle again at t+3.
    tbl.push_back(mk(1'b1, 1'b1, 8'd5,  32'd7,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd5,  32'd7,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    // Accumulate onto memory word 10 at addr 3.
    tbl.push_back(mk(1'b1, 1'b0, 8'd3,  32'd4,   1'b1, 1'b0, 8'd0,  32'd0,   1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd3,  32'd14,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    // Five back-to-back updates to addr 9 (memory holds 555, which is overwritten).
    tbl.push_back(mk(1'b1, 1'b1, 8'd9,  32'd1,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'd9,  32'd2,   1'b1, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd9,  32'd3,   1'b1, 1'b1, 8'd9,  32'd1,   1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd9,  32'd4,   1'b1, 1'b1, 8'd9,  32'd3,   1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd9,  32'd5,   1'b1, 1'b1, 8'd9,  32'd6,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd9,  32'd10,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd9,  32'd15,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    // Gap pattern on addr 2 (memory holds 777): needs the delayed-write forward.
    tbl.push_back(mk(1'b1, 1'b1, 8'd2,  32'd100, 1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd2,  32'd1,   1'b1, 1'b1, 8'd2,  32'd100, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd2,  32'd1,   1'b1, 1'b1, 8'd2,  32'd101, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd2,  32'd102, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    // Max positive word plus 1: wraps or saturates depending on the build.
    tbl.push_back(mk(1'b1, 1'b0, 8'd20, 32'd1,   1'b1, 1'b0, 8'd0,  32'd0,   1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd20, wrap_exp, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));
    // Negative partial sum onto addr 5 (now 7): 7 - 10 = -3.
    tbl.push_back(mk(1'b1, 1'b0, 8'd5,  32'hFFFF_FFF6, 1'b1, 1'b0, 8'd0, 32'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b1, 8'd5,  32'hFFFF_FFFD, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd0,  32'd0,   1'b0, 1'b0, 8'd0,  32'd0,   1'b1));

    // Reset, with the preloads done underneath it.
    rst = 1'b1;
    drive_idle();
    load(0, 8'd3,  32'd10);
    load(0, 8'd9,  32'd555);
    load(0, 8'd2,  32'd777);
    load(0, 8'd5,  32'd999);
    load(0, 8'd20, 32'h7FFF_FFFF);
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    chk("reset wr_en",   32'(mem_wr_en),   32'd0);
    chk("reset wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("reset wr_data", mem_wr_data[31:0], 32'd0);
    chk("reset idle",    32'(idle),        32'd1);
`ifdef ACCUM_WB_SAT_EN
    chk("reset sat_flag", 32'(sat_flag), 32'd0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive_idle();
      psum_valid[0]     = tbl[i].v;
      psum_first[0]     = tbl[i].f;
      psum_addr[AW-1:0] = tbl[i].a;
      psum_data[DW-1:0] = tbl[i].p;
      #1;
      chk($sformatf("row%0d rd_en", i), 32'(mem_rd_en[0]), 32'(tbl[i].erd));
      if (tbl[i].erd) chk($sformatf("row%0d rd_addr", i), 32'(mem_rd_addr[AW-1:0]),
                          32'(tbl[i].a));
      chk($sformatf("row%0d wr_en", i), 32'(mem_wr_en), 32'(tbl[i].ewr));
      if (tbl[i].ewr) begin
        chk($sformatf("row%0d wr_addr", i), 32'(mem_wr_addr[AW-1:0]), 32'(tbl[i].ewa));
        chk($sformatf("row%0d wr_data", i), mem_wr_data[DW-1:0], tbl[i].ewd);
      end
      chk($sformatf("row%0d idle", i), 32'(idle), 32'(tbl[i].eidle));
    end
`ifdef ACCUM_WB_SAT_EN
    chk("sat_flag after clamp", 32'(sat_flag), 32'd1);
`endif

    // Random mixed traffic on 4 lanes over a small address range, checked against a
    // sequential-sum scoreboard.
    for (int l = 0; l < NL; l++) begin
      for (int a = 0; a < 4; a++) begin
        gold[l][a] = DW'($urandom_range(0, 1000));
        load(l, AW'(a), gold[l][a]);
      end
    end
    @(negedge clk);
    ld_en = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      drive_idle();
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 3) != 0) begin
          int            a;
          logic          f;
          logic [DW-1:0] p;
          a = int'($urandom_range(0, 3));
          f = ($urandom_range(0, 4) == 0);
          p = DW'(int'($urandom_range(0, 2000)) - 1000);
          psum_valid[l]          = 1'b1;
          psum_first[l]          = f;
          psum_addr[l*AW +: AW]  = AW'(a);
          psum_data[l*DW +: DW]  = p;
          gold[l][a] = f ? p : gold[l][a] + p;
        end
      end
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    chk("random drained idle", 32'(idle), 32'd1);
    for (int l = 0; l < NL; l++) begin
      for (int a = 0; a < 4; a++) begin
        chk($sformatf("random lane%0d addr%0d", l, a), mem[l][a], gold[l][a]);
      end
    end

    // Reset while writes are in flight.
    @(negedge clk);
    drive_idle();
    psum_valid[0] = 1'b1; psum_first[0] = 1'b1; psum_addr[AW-1:0] = 8'd7;
    psum_data[DW-1:0] = 32'd5;
    @(negedge clk);
    psum_first[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst write in flight", 32'(mem_wr_en), 32'd1);
    @(posedge clk);
    #1;
    chk("midrst wr_en cleared", 32'(mem_wr_en), 32'd0);
    chk("midrst idle",          32'(idle),      32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst no write %0d", k), 32'(mem_wr_en), 32'd0);
    end
    chk("postrst idle", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
